// File: rtl/line_commit_writer.sv
// ---------------------------------------------------------------------------
// line_commit_writer
//
// Accepts one compress_commit_reg block at a time and writes its 0, 1 or 2
// cache lines to a 64-byte-beat memory write port. Each beat goes to an
// internal write pointer, which advances by 64 on every beat and wraps
// modulo 2^ADDR_W.
//
// Optional feature: define COMMIT_STATS_EN to build the block/line statistic
// counters. When it is undefined, the stat_* outputs are tied to zero.
//
// Parameters
//   ADDR_W         byte-address width of the memory write port
//   BASE_ADDR      first address written after reset or pointer clear
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   in_valid       block presented on in_commit
//   in_ready       block accepted when in_valid && in_ready
//   in_commit      packed compress_commit_reg, MSB first:
//                    [1026] compressable, [1025:1024] flag,
//                    [1023:512] lines.l1, [511:0] lines.l2
//   ptr_clr        return write pointer to BASE_ADDR (honoured only in IDLE)
//   mem_valid      write beat valid
//   mem_ready      memory accepts beat when mem_valid && mem_ready
//   mem_addr       64-byte-aligned beat address
//   mem_data       raw line data
//   mem_last       final beat of current block
//   mem_compressed compressable bit of current block
//   stat_blocks, stat_cmp_blocks, stat_lines   32-bit wrapping statistics
// ---------------------------------------------------------------------------
module line_commit_writer #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1026:0]     in_commit,
    input  logic              ptr_clr,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [511:0]      mem_data,
    output logic              mem_last,
    output logic              mem_compressed,
    output logic [31:0]       stat_blocks,
    output logic [31:0]       stat_cmp_blocks,
    output logic [31:0]       stat_lines
);

    typedef logic [511:0] line_t;

    typedef struct packed {
        line_t l1;
        line_t l2;
    } commit_lines_t;

    typedef struct packed {
        logic          compressable;
        logic [1:0]    flag;
        commit_lines_t lines;
    } compress_commit_reg_t;

    typedef enum logic [1:0] {
        IDLE,
        BEAT1,
        BEAT2
    } state_t;

    // Pointer addresses are always line aligned, even if BASE_ADDR is not.
    localparam logic [ADDR_W-1:0] BASE_ALIGNED = {BASE_ADDR[ADDR_W-1:6], 6'd0};
    localparam logic [ADDR_W-1:0] LINE_BYTES   = ADDR_W'(64);

    compress_commit_reg_t commit;
    state_t               state_q;
    logic [ADDR_W-1:0]    wr_ptr_q;
    logic [ADDR_W-1:0]    wr_ptr_inc;
    line_t                l2_q;
    logic                 mem_valid_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    line_t                mem_data_q;
    logic                 mem_last_q;
    logic                 mem_compressed_q;
    logic                 accept;
    logic                 mem_fire;

    assign commit     = compress_commit_reg_t'(in_commit);
    // A pointer clear takes the IDLE cycle, so nothing may be accepted then.
    assign in_ready   = (state_q == IDLE) && !ptr_clr && !rst;
    assign accept     = in_valid && in_ready;
    assign mem_fire   = mem_valid_q && mem_ready;
    assign wr_ptr_inc = wr_ptr_q + LINE_BYTES;

    assign mem_valid      = mem_valid_q;
    assign mem_addr       = mem_addr_q;
    assign mem_data       = mem_data_q;
    assign mem_last       = mem_last_q;
    assign mem_compressed = mem_compressed_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the wide data registers are reset as well, because
            // mem_data must read zero after reset.
            state_q          <= IDLE;
            wr_ptr_q         <= BASE_ALIGNED;
            l2_q             <= '0;
            mem_valid_q      <= 1'b0;
            mem_addr_q       <= BASE_ALIGNED;
            mem_data_q       <= '0;
            mem_last_q       <= 1'b0;
            mem_compressed_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ptr_clr) begin
                        wr_ptr_q <= BASE_ALIGNED;
                    end else if (accept) begin
                        mem_compressed_q <= commit.compressable;
                        mem_data_q       <= commit.lines.l1;
                        l2_q             <= commit.lines.l2;
                        mem_addr_q       <= wr_ptr_q;
                        // flag 00 is a zero-beat block: it is counted but
                        // the FSM stays in IDLE.
                        if (commit.flag != 2'b00) begin
                            mem_valid_q <= 1'b1;
                            mem_last_q  <= ~commit.flag[1];
                            state_q     <= BEAT1;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_fire) begin
                        wr_ptr_q <= wr_ptr_inc;
                        // mem_last low in BEAT1 means l2 still has to go out.
                        if (!mem_last_q) begin
                            mem_data_q <= l2_q;
                            mem_addr_q <= wr_ptr_inc;
                            mem_last_q <= 1'b1;
                            state_q    <= BEAT2;
                        end else begin
                            mem_valid_q <= 1'b0;
                            mem_last_q  <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                BEAT2: begin
                    if (mem_fire) begin
                        wr_ptr_q    <= wr_ptr_inc;
                        mem_valid_q <= 1'b0;
                        mem_last_q  <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef COMMIT_STATS_EN
    logic [31:0] stat_blocks_q,     stat_blocks_d;
    logic [31:0] stat_cmp_blocks_q, stat_cmp_blocks_d;
    logic [31:0] stat_lines_q,      stat_lines_d;

    // NOTE: every always_comb output is assigned on every path, so no
    // latches can be inferred.
    always_comb begin
        stat_blocks_d     = stat_blocks_q + 32'(accept);
        stat_cmp_blocks_d = stat_cmp_blocks_q + 32'(accept && commit.compressable);
        stat_lines_d      = stat_lines_q + 32'(mem_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_blocks_q     <= '0;
            stat_cmp_blocks_q <= '0;
            stat_lines_q      <= '0;
        end else begin
            stat_blocks_q     <= stat_blocks_d;
            stat_cmp_blocks_q <= stat_cmp_blocks_d;
            stat_lines_q      <= stat_lines_d;
        end
    end

    assign stat_blocks     = stat_blocks_q;
    assign stat_cmp_blocks = stat_cmp_blocks_q;
    assign stat_lines      = stat_lines_q;
`else
    assign stat_blocks     = '0;
    assign stat_cmp_blocks = '0;
    assign stat_lines      = '0;
`endif

endmodule

// File: tb/tb_line_commit_writer.sv
// ---------------------------------------------------------------------------
// tb_line_commit_writer
//
// Self-checking bench for line_commit_writer, built with ADDR_W=8 so that
// address wrap is reachable. Expected beats are pushed to a scoreboard queue
// on accept. A negedge monitor compares every valid beat against the head of
// the queue and pops the head on handshake. A table of blocks drives the main
// traffic. Hand-written sequences cover ptr_clr and mid-block reset.
// ---------------------------------------------------------------------------
module tb_line_commit_writer;

    localparam int unsigned ADDR_W = 8;

    typedef logic [511:0] val_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [511:0]      data;
        logic              last;
        logic              cmp;
    } beat_t;

    typedef struct {
        logic [1:0] flag;
        logic       cmp;
        int         stall;
        int         exp_beats;
    } vec_t;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1026:0]     in_commit;
    logic              ptr_clr;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [511:0]      mem_data;
    logic              mem_last;
    logic              mem_compressed;
    logic [31:0]       stat_blocks;
    logic [31:0]       stat_cmp_blocks;
    logic [31:0]       stat_lines;

    beat_t             q[$];
    logic [ADDR_W-1:0] model_ptr;
    logic [31:0]       model_blocks;
    logic [31:0]       model_cmp;
    logic [31:0]       model_lines;
    int                n_vec;
    int                n_err;
    vec_t              tbl[6];

    line_commit_writer #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(8'h00)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_commit      (in_commit),
        .ptr_clr        (ptr_clr),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_last       (mem_last),
        .mem_compressed (mem_compressed),
        .stat_blocks    (stat_blocks),
        .stat_cmp_blocks(stat_cmp_blocks),
        .stat_lines     (stat_lines)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input val_t act, input val_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] pat(input logic [31:0] seed);
        return {16{seed}};
    endfunction

    // Scoreboard monitor. The handshake happens on the posedge that follows
    // this negedge, so the head of the queue is popped here.
    always @(negedge clk) begin
        if (!rst) begin
            check("mem_valid", val_t'(mem_valid), val_t'(q.size() != 0));
            if (mem_valid && q.size() != 0) begin
                check("mem_addr", val_t'(mem_addr), val_t'(q[0].addr));
                check("mem_data", mem_data, q[0].data);
                check("mem_last", val_t'(mem_last), val_t'(q[0].last));
                check("mem_compressed", val_t'(mem_compressed), val_t'(q[0].cmp));
                if (mem_ready) begin
                    void'(q.pop_front());
                    model_lines = model_lines + 32'd1;
                end
            end
        end
    end

    task automatic check_stats(input string tag);
`ifdef COMMIT_STATS_EN
        check({tag, "_stat_blocks"}, val_t'(stat_blocks), val_t'(model_blocks));
        check({tag, "_stat_cmp_blocks"}, val_t'(stat_cmp_blocks), val_t'(model_cmp));
        check({tag, "_stat_lines"}, val_t'(stat_lines), val_t'(model_lines));
`else
        check({tag, "_stat_blocks"}, val_t'(stat_blocks), '0);
        check({tag, "_stat_cmp_blocks"}, val_t'(stat_cmp_blocks), '0);
        check({tag, "_stat_lines"}, val_t'(stat_lines), '0);
`endif
    endtask

    task automatic accept(input logic [1:0] flag, input logic cmp,
                          input logic [511:0] l1, input logic [511:0] l2,
                          input int exp_beats, input logic ready);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("in_ready_before_accept", val_t'(in_ready), val_t'(1'b1));
        in_valid  = 1'b1;
        in_commit = {cmp, flag, l1, l2};
        mem_ready = ready;
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        model_blocks = model_blocks + 32'd1;
        if (cmp) model_cmp = model_cmp + 32'd1;
        if (exp_beats >= 1) begin
            q.push_back('{addr: model_ptr, data: l1, last: (exp_beats == 1), cmp: cmp});
            model_ptr = model_ptr + 8'd64;
        end
        if (exp_beats == 2) begin
            q.push_back('{addr: model_ptr, data: l2, last: 1'b1, cmp: cmp});
            model_ptr = model_ptr + 8'd64;
        end
        check("valid_after_accept", val_t'(mem_valid), val_t'(exp_beats != 0));
        check("in_ready_after_accept", val_t'(in_ready), val_t'(exp_beats == 0));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain", val_t'(q.size() == 0), val_t'(1'b1));
    endtask

    task automatic send_block(input logic [1:0] flag, input logic cmp,
                              input logic [511:0] l1, input logic [511:0] l2,
                              input int stall, input int exp_beats);
        accept(flag, cmp, l1, l2, exp_beats, stall == 0);
        if (stall > 0) begin
            repeat (stall) begin
                @(posedge clk);
                #1;
            end
            mem_ready = 1'b1;
        end
        wait_drain();
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        model_ptr    = 8'h00;
        model_blocks = '0;
        model_cmp    = '0;
        model_lines  = '0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_commit    = '0;
        ptr_clr      = 1'b0;
        mem_ready    = 1'b0;

        // Addresses: 00,40 | 80 | none | C0,00 (wrap) | 40,80 | C0 -> ptr 00
        tbl[0] = '{flag: 2'b10, cmp: 1'b0, stall: 0, exp_beats: 2};
        tbl[1] = '{flag: 2'b01, cmp: 1'b1, stall: 5, exp_beats: 1};
        tbl[2] = '{flag: 2'b00, cmp: 1'b0, stall: 0, exp_beats: 0};
        tbl[3] = '{flag: 2'b11, cmp: 1'b1, stall: 2, exp_beats: 2};
        tbl[4] = '{flag: 2'b10, cmp: 1'b1, stall: 0, exp_beats: 2};
        tbl[5] = '{flag: 2'b01, cmp: 1'b0, stall: 1, exp_beats: 1};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", val_t'(in_ready), val_t'(1'b0));
        check("rst_mem_valid", val_t'(mem_valid), val_t'(1'b0));
        check("rst_mem_last", val_t'(mem_last), val_t'(1'b0));
        check("rst_mem_compressed", val_t'(mem_compressed), val_t'(1'b0));
        check("rst_mem_addr", val_t'(mem_addr), val_t'(8'h00));
        check("rst_mem_data", mem_data, '0);
        check_stats("rst");
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", val_t'(in_ready), val_t'(1'b1));

        // Table-driven blocks.
        for (int i = 0; i < 6; i++) begin
            send_block(tbl[i].flag, tbl[i].cmp,
                       pat(32'hA000_0000 | 32'(i)), pat(32'hB000_0000 | 32'(i)),
                       tbl[i].stall, tbl[i].exp_beats);
        end
        check_stats("table");

        // ptr_clr held during BEAT1 and BEAT2 stalls must be ignored.
        accept(2'b10, 1'b0, pat(32'hC1C1_0001), pat(32'hC2C2_0002), 2, 1'b0);
        ptr_clr = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        ptr_clr   = 1'b0;
        mem_ready = 1'b1;
        wait_drain();
        // The pointer continues from 0x80.
        send_block(2'b01, 1'b0, pat(32'hD0D0_0003), pat(32'hD1D1_0004), 0, 1);

        // ptr_clr in IDLE clears the pointer and blocks a concurrent accept.
        in_valid  = 1'b1;
        in_commit = {1'b1, 2'b01, pat(32'hEEEE_0005), pat(32'hEEEE_0006)};
        ptr_clr   = 1'b1;
        #1;
        check("in_ready_during_ptr_clr", val_t'(in_ready), val_t'(1'b0));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        ptr_clr   = 1'b0;
        model_ptr = 8'h00;
        send_block(2'b01, 1'b0, pat(32'hE0E0_0007), pat(32'hE1E1_0008), 0, 1);
        check_stats("ptr_clr");

        // Reset in BEAT1 abandons the block.
        accept(2'b11, 1'b1, pat(32'hF0F0_0009), pat(32'hF1F1_000A), 2, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_mem_valid", val_t'(mem_valid), val_t'(1'b0));
        check("midrst_in_ready", val_t'(in_ready), val_t'(1'b0));
        check("midrst_mem_addr", val_t'(mem_addr), val_t'(8'h00));
        check("midrst_mem_last", val_t'(mem_last), val_t'(1'b0));
        check("midrst_mem_compressed", val_t'(mem_compressed), val_t'(1'b0));
        check("midrst_mem_data", mem_data, '0);
        q.delete();
        model_ptr    = 8'h00;
        model_blocks = '0;
        model_cmp    = '0;
        model_lines  = '0;
        rst          = 1'b0;
        mem_ready    = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("in_ready_after_midrst", val_t'(in_ready), val_t'(1'b1));
        check_stats("midrst");

        // Three blocks after reset: flags 01,10,11 and compressable 1,0,1.
        send_block(2'b01, 1'b1, pat(32'h1111_0001), pat(32'h1111_0002), 0, 1);
        send_block(2'b10, 1'b0, pat(32'h2222_0001), pat(32'h2222_0002), 1, 2);
        send_block(2'b11, 1'b1, pat(32'h3333_0001), pat(32'h3333_0002), 0, 2);
        check_stats("three_blocks");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/line_commit_writer.md
LINE_COMMIT_WRITER -- requirements
Module: line_commit_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of the memory write port.
REQ-002 SHALL have parameter BASE_ADDR, default 0, first byte address written after reset or pointer clear.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  a compress_commit_reg block is presented.
REQ-006 SHALL have port in_ready  output  1  block accepted when in_valid && in_ready.
REQ-007 SHALL have port in_commit  input  compress_commit_reg  compressable, flag[1:0], lines.l1/l2 (line_t, 512 b each).
REQ-008 SHALL have port ptr_clr  input  1  request to return write pointer to BASE_ADDR.
REQ-009 SHALL have port mem_valid  output  1  write beat valid.
REQ-010 SHALL have port mem_ready  input  1  memory accepts beat when mem_valid && mem_ready.
REQ-011 SHALL have port mem_addr  output  ADDR_W  64-byte-aligned beat address.
REQ-012 SHALL have port mem_data  output  512  line_t raw.
REQ-013 SHALL have port mem_last  output  1  final beat of current block.
REQ-014 SHALL have port mem_compressed  output  1  registered compressable bit of current block.
REQ-015 SHALL have ports stat_blocks, stat_cmp_blocks, stat_lines  output  32 each  statistics (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, BEAT1, BEAT2.
REQ-017 in_ready SHALL be 1 only in IDLE with ptr_clr low; 0 in BEAT1/BEAT2.
REQ-018 On accept, SHALL register entire in_commit; beat count: flag 2'b00 -> 0 beats, 2'b01 -> 1 beat (l1), 2'b10 or 2'b11 -> 2 beats (l1 then l2).
REQ-019 Accept with 0 beats SHALL stay in IDLE, issue no mem beat, still count as a block in stat_blocks.
REQ-020 Accept with >=1 beat SHALL enter BEAT1; mem_valid SHALL rise the cycle after accept (latency 1) carrying l1.
REQ-021 BEAT1 SHALL present mem_data=l1, mem_addr=wr_ptr, mem_last=1 iff 1-beat block.
REQ-022 BEAT1 handshake: wr_ptr += 64; go to BEAT2 for 2-beat block, else IDLE.
REQ-023 BEAT2 SHALL present mem_data=l2, mem_addr=wr_ptr, mem_last=1; on handshake wr_ptr += 64, go to IDLE.
REQ-024 While mem_valid && !mem_ready, mem_valid/addr/data/last/compressed SHALL hold stable.
REQ-025 mem_valid SHALL be 0 in IDLE; no beat without a prior accept.
REQ-026 wr_ptr SHALL wrap modulo 2^ADDR_W; low 6 bits always 0.
REQ-027 ptr_clr high in IDLE: wr_ptr := BASE_ADDR next cycle, no accept that cycle; ptr_clr outside IDLE ignored (not latched).
REQ-028 Back-to-back: after last handshake, next accept possible earliest one cycle later (IDLE).

Reset
REQ-029 rst SHALL force IDLE, wr_ptr=BASE_ADDR, mem_valid=0, mem_last=0, mem_compressed=0, mem_addr=BASE_ADDR, mem_data=0, in_ready=0 during reset, stat counters=0.
REQ-030 rst mid-block SHALL abandon remaining beats; no beat issued after reset deasserts until a new accept.

Configuration
REQ-031 With COMMIT_STATS_EN defined: stat_blocks += 1 per accept, stat_cmp_blocks += 1 per accept with compressable=1, stat_lines += 1 per mem handshake; 32-bit, wrap at 2^32.
REQ-032 Without COMMIT_STATS_EN: stat_* ports SHALL be tied 0, no counter registers.

Verification
REQ-033 Reset, then accept flag=2'b10, compressable=0, l1=A, l2=B, mem_ready=1 -> beats at 0x0 (A, last=0) and 0x40 (B, last=1), wr_ptr=0x80.
REQ-034 Accept flag=2'b01, compressable=1, mem_ready held 0 for 5 cycles -> l1 held stable at same addr 5 cycles, single beat last=1 compressed=1 on ready.
REQ-035 Accept flag=2'b00 -> no mem_valid, in_ready back high next cycle, wr_ptr unchanged, stat_blocks=1 (with COMMIT_STATS_EN).
REQ-036 ADDR_W=8, wr_ptr=0xC0, 2-beat block -> addresses 0xC0, 0x00.
REQ-037 rst asserted in BEAT1 -> mem_valid 0 next cycle, wr_ptr=BASE_ADDR; ptr_clr in BEAT2 -> ignored, next beat at wr_ptr+64.
REQ-038 With COMMIT_STATS_EN, 3 blocks (flags 01,10,11; compressable 1,0,1) -> stat_blocks=3, stat_cmp_blocks=2, stat_lines=5; without macro all stat_*=0.
